// File: rtl/alphabet_map_pkg.sv
// Shared font ROM and character-code constants for the text overlay renderer.
// Glyph rows are packed top-to-bottom, MSB row first; within a row bit 4 is the leftmost column.
package alphabet_map_pkg;

    localparam int DEF_GLYPH_W = 5;
    localparam int DEF_GLYPH_H = 7;
    localparam int FONT_CODES  = 36;

    typedef logic [5:0]                         char_code_t;
    typedef logic [DEF_GLYPH_W-1:0]             font_row_t;
    typedef logic [DEF_GLYPH_W*DEF_GLYPH_H-1:0] glyph_t;

    localparam char_code_t CHAR_A         = 6'd0;
    localparam char_code_t CHAR_DIGIT0    = 6'd26;
    localparam char_code_t CHAR_BLANK_MIN = 6'd36;

    localparam glyph_t FONT_ROM [0:FONT_CODES-1] = '{
        35'b01110_10001_10001_11111_10001_10001_10001, // A
        35'b11110_10001_10001_11110_10001_10001_11110, // B
        35'b01110_10001_10000_10000_10000_10001_01110, // C
        35'b11110_10001_10001_10001_10001_10001_11110, // D
        35'b11111_10000_10000_11110_10000_10000_11111, // E
        35'b11111_10000_10000_11110_10000_10000_10000, // F
        35'b01110_10001_10000_10111_10001_10001_01111, // G
        35'b10001_10001_10001_11111_10001_10001_10001, // H
        35'b01110_00100_00100_00100_00100_00100_01110, // I
        35'b00111_00010_00010_00010_00010_10010_01100, // J
        35'b10001_10010_10100_11000_10100_10010_10001, // K
        35'b10000_10000_10000_10000_10000_10000_11111, // L
        35'b10001_11011_10101_10101_10001_10001_10001, // M
        35'b10001_10001_11001_10101_10011_10001_10001, // N
        35'b01110_10001_10001_10001_10001_10001_01110, // O
        35'b11110_10001_10001_11110_10000_10000_10000, // P
        35'b01110_10001_10001_10001_10101_10010_01101, // Q
        35'b11110_10001_10001_11110_10100_10010_10001, // R
        35'b01111_10000_10000_01110_00001_00001_11110, // S
        35'b11111_00100_00100_00100_00100_00100_00100, // T
        35'b10001_10001_10001_10001_10001_10001_01110, // U
        35'b10001_10001_10001_10001_10001_01010_00100, // V
        35'b10001_10001_10001_10101_10101_10101_01010, // W
        35'b10001_10001_01010_00100_01010_10001_10001, // X
        35'b10001_10001_01010_00100_00100_00100_00100, // Y
        35'b11111_00001_00010_00100_01000_10000_11111, // Z
        35'b01110_10001_10011_10101_11001_10001_01110, // 0
        35'b00100_01100_00100_00100_00100_00100_01110, // 1
        35'b01110_10001_00001_00010_00100_01000_11111, // 2
        35'b11111_00010_00100_00010_00001_10001_01110, // 3
        35'b00010_00110_01010_10010_11111_00010_00010, // 4
        35'b11111_10000_11110_00001_00001_10001_01110, // 5
        35'b00110_01000_10000_11110_10001_10001_01110, // 6
        35'b11111_00001_00010_00100_01000_01000_01000, // 7
        35'b01110_10001_10001_01110_10001_10001_01110, // 8
        35'b01110_10001_10001_01111_00001_00010_01100  // 9
    };

endpackage

// File: rtl/alphabet_map_glyph_rom.sv
// Combinational font lookup: (letter, row) -> 5 row bits, bit 4 = leftmost column.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; blank codes and rows past the glyph return all zeros.
module alphabet_map_glyph_rom
    import alphabet_map_pkg::*;
(
    input  logic [5:0] letter,
    input  logic [2:0] row,
    output logic [4:0] row_bits
);

    glyph_t glyph;

    always_comb begin
        glyph    = '0;
        row_bits = '0;
        if (letter < CHAR_BLANK_MIN) begin
            glyph = FONT_ROM[letter];
            case (row)
                3'd0:    row_bits = glyph[34:30];
                3'd1:    row_bits = glyph[29:25];
                3'd2:    row_bits = glyph[24:20];
                3'd3:    row_bits = glyph[19:15];
                3'd4:    row_bits = glyph[14:10];
                3'd5:    row_bits = glyph[9:5];
                3'd6:    row_bits = glyph[4:0];
                default: row_bits = '0;
            endcase
        end
    end

endmodule

// File: rtl/alphabet_map.sv
// Per-pixel glyph renderer: flags scan pixels that land on a lit font pixel of one character cell.
// Latency: 1 cycle from coordinate/base/letter inputs to pixel_on.
// Backpressure: none; inputs sampled every cycle, output is OR-able with sibling instances.
module alphabet_map
    import alphabet_map_pkg::*;
#(
    parameter int SCALE   = 2,
    parameter int GLYPH_W = DEF_GLYPH_W,
    parameter int GLYPH_H = DEF_GLYPH_H
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] VGA_HORZ_COORD,
    input  logic [11:0] VGA_VERT_COORD,
    input  logic [11:0] base_horz,
    input  logic [11:0] base_vert,
    input  logic [5:0]  letter,
    output logic        pixel_on
);

    localparam logic [11:0] CELL_W  = 12'(GLYPH_W * SCALE);
    localparam logic [11:0] CELL_H  = 12'(GLYPH_H * SCALE);
    localparam logic [11:0] SCALE_V = 12'(SCALE);

    logic [11:0] dx;
    logic [11:0] dy;
    logic        in_cell;
    logic [2:0]  col;
    logic [2:0]  row;
    logic [4:0]  row_bits;
    logic [4:0]  shifted;

    // 12-bit wrap keeps glyphs anchored near 4095 contiguous across the screen edge.
    assign dx      = VGA_HORZ_COORD - base_horz;
    assign dy      = VGA_VERT_COORD - base_vert;
    assign in_cell = (dx < CELL_W) && (dy < CELL_H);

    // Truncation may alias outside the cell, but in_cell masks those cases.
    assign col = 3'(dx / SCALE_V);
    assign row = 3'(dy / SCALE_V);

    alphabet_map_glyph_rom u_glyph_rom (
        .letter   (letter),
        .row      (row),
        .row_bits (row_bits)
    );

    assign shifted = row_bits << col;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= in_cell & shifted[4];
        end
    end

endmodule

// File: tb/tb_alphabet_map.sv
// Scoreboard bench for alphabet_map: expected pixel bits queued at drive time, popped one cycle later.
module tb_alphabet_map;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] hc = '0;
    logic [11:0] vc = '0;
    logic [11:0] bh = '0;
    logic [11:0] bv = '0;
    logic [5:0]  letter = '0;
    logic        pixel_on;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic  exp;
    } sb_t;

    sb_t sb_q[$];

    // Reference glyphs for the codes the bench predicts exactly: A, I, 0, 1.
    logic [4:0] ref_font [4][7];

    alphabet_map dut (
        .clk            (clk),
        .rstn           (rstn),
        .VGA_HORZ_COORD (hc),
        .VGA_VERT_COORD (vc),
        .base_horz      (bh),
        .base_vert      (bv),
        .letter         (letter),
        .pixel_on       (pixel_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ref_pix(input logic [11:0] h, input logic [11:0] v,
                                     input logic [11:0] b_h, input logic [11:0] b_v,
                                     input logic [5:0] code);
        logic [11:0] ddx;
        logic [11:0] ddy;
        int          idx;
        logic [4:0]  r;
        ddx = h - b_h;
        ddy = v - b_v;
        if (ddx >= 12'd10 || ddy >= 12'd14) return 1'b0;
        case (code)
            6'd0:    idx = 0;
            6'd8:    idx = 1;
            6'd26:   idx = 2;
            6'd27:   idx = 3;
            default: return 1'b0;
        endcase
        r = ref_font[idx][int'(ddy) / 2];
        return r[4 - int'(ddx) / 2];
    endfunction

    task automatic drive(input string tag, input int h, input int v, input int b_h,
                         input int b_v, input int code);
        sb_t e;
        hc     = 12'(h);
        vc     = 12'(v);
        bh     = 12'(b_h);
        bv     = 12'(b_v);
        letter = 6'(code);
        e.tag  = tag;
        e.exp  = rstn ? ref_pix(hc, vc, bh, bv, letter) : 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.tag, 32'(pixel_on), 32'(e.exp));
    endtask

    initial begin
        int lit;
        int codes[8];

        ref_font[0] = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
        ref_font[1] = '{5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
        ref_font[2] = '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
        ref_font[3] = '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
        codes = '{0, 8, 26, 27, 36, 40, 50, 63};

        // Reset holds the output low even on a lit pixel.
        rstn = 1'b0;
        drive("rst_hold0", 102, 6, 100, 6, 0);
        drive("rst_hold1", 102, 6, 100, 6, 0);
        rstn = 1'b1;
        drive("rst_release", 102, 6, 100, 6, 0);

        // 'A' scan, each result one cycle after its coordinate.
        drive("a_r0c0", 100, 6, 100, 6, 0);
        @(negedge clk);
        hc = 12'd102;
        #1;
        check("latency_hold", 32'(pixel_on), 32'd0);
        drive("a_r0c1", 102, 6, 100, 6, 0);
        drive("a_r3c0", 100, 12, 100, 6, 0);
        drive("a_r6c4", 109, 19, 100, 6, 0);

        // Exclusive right/bottom edges and one pixel before the anchor.
        drive("edge_right", 110, 6, 100, 6, 0);
        drive("edge_left", 99, 6, 100, 6, 0);
        drive("edge_bottom", 102, 20, 100, 6, 0);
        drive("edge_top", 102, 5, 100, 6, 0);

        // Anchor near 4095 wraps across column 0.
        drive("wrap_in", 0, 70, 4090, 64, 0);
        drive("wrap_out", 4, 64, 4090, 64, 0);

        // Digits and blank codes.
        drive("one_r0c2", 204, 6, 200, 6, 27);
        drive("one_r0c0", 200, 6, 200, 6, 27);
        lit = 0;
        for (int y = 0; y < 14; y++) begin
            for (int x = 0; x < 10; x++) begin
                hc = 12'(200 + x);
                vc = 12'(6 + y);
                letter = 6'd40;
                @(posedge clk);
                #1;
                if (pixel_on) lit++;
            end
        end
        check("blank40_lit_count", 32'(lit), 32'd0);

        // Letter changes with coordinate held.
        drive("chg_a_c0", 200, 6, 200, 6, 0);
        drive("chg_i_c0", 200, 6, 200, 6, 8);
        drive("chg_i_c1", 202, 6, 200, 6, 8);
        drive("chg_0_c1", 202, 6, 200, 6, 26);
        drive("chg_63_c1", 202, 6, 200, 6, 63);

        // Every non-blank glyph lights something; none lights past the cell edge.
        for (int c = 0; c < 36; c++) begin
            lit = 0;
            for (int y = 0; y < 14; y++) begin
                for (int x = 0; x < 10; x++) begin
                    hc = 12'(300 + x);
                    vc = 12'(100 + y);
                    bh = 12'd300;
                    bv = 12'd100;
                    letter = 6'(c);
                    @(posedge clk);
                    #1;
                    if (pixel_on) lit++;
                end
            end
            check($sformatf("lit_code%0d", c), 32'(lit > 0), 32'd1);
            drive($sformatf("outside_code%0d", c), 310, 100 + (c % 14), 300, 100, c);
        end

        // Random coordinates around a wrapping anchor for the modelled codes.
        for (int n = 0; n < 300; n++) begin
            int b_h;
            int b_v;
            b_h = (n % 3 == 0) ? 4092 : 500;
            b_v = (n % 5 == 0) ? 4090 : 40;
            drive($sformatf("rand%0d", n),
                  (b_h + int'($urandom_range(0, 15)) - 3) % 4096,
                  (b_v + int'($urandom_range(0, 19)) - 3) % 4096,
                  b_h, b_v, codes[$urandom_range(0, 7)]);
        end

        // Reset mid-stream clears the output again.
        rstn = 1'b0;
        drive("rst_mid", 102, 6, 100, 6, 0);
        rstn = 1'b1;
        drive("rst_mid_release", 102, 6, 100, 6, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
